seq_right_shifter: RTL and testbench

//  Multi-cycle right rotate/shift unit; the right-direction counterpart to the datapath's

---
 rtl/seq_right_shifter_if.sv | 59 +++++
 rtl/seq_right_shifter.sv | 166 ++++++++++++++++
 tb/tb_seq_right_shifter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seq_right_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_right_shifter_if
// Description : Operand/result handshake bundle for seq_right_shifter.
//               The operand side carries in_valid/in_ready with the operand,
//               shift count and op code. The result side carries
//               out_valid/out_ready with the result, plus a busy status.
// Modports    : slave  - the shifter (accepts operands, produces results)
//               master - the requester (drives operands, takes results)
// Signals     : in_valid  1      operand request
//               in_ready  1      unit can accept an operand
//               in_data   WIDTH  operand
//               in_cnt    CNT_W  shift amount, 0..WIDTH-1
//               in_op     2      00=ROR, 01=SRL, 10=SRA, 11=ROR
//               out_valid 1      result available
//               out_ready 1      consumer takes the result
//               out_data  WIDTH  result, meaningful while out_valid=1
//               busy      1      operation in flight or result pending
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_right_shifter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_cnt,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    output in_cnt,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/seq_right_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_right_shifter
// Description : Multi-cycle right rotate / logical shift / arithmetic shift
//               unit (ROR, SRL, SRA). One operand is accepted on the input
//               handshake, shifted iteratively in a work register, and the
//               result is returned on the output handshake.
// Parameters  : WIDTH - operand/result width (default 16)
//               CNT_W - shift-count width, equal to log2(WIDTH) (default 4);
//                       both must match the parameters of the bus interface.
// Ports       : clk  in  system clock, rising edge
//               rst  in  asynchronous, active-high reset
//               bus  seq_right_shifter_if.slave
//                    in_valid/in_ready/in_data/in_cnt/in_op   operand side
//                    out_valid/out_ready/out_data             result side
//                    busy                                     BUSY or DONE
// Build macro : SEQ_SHIFT_NIBBLE_EN - when defined, a BUSY step with at least
//               four bits remaining shifts by four at once, cutting latency
//               to floor(cnt/4)+(cnt%4)+1. Results are identical either way.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_right_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_right_shifter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  // 2'b11 decodes as ROR through the default arm of the step functions.

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Single-bit right step. The vacated MSB is filled from bit 0 (rotate),
  // with zero (logical) or with the current sign bit (arithmetic).
  // --------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] w,
                                             input logic [1:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SRL:  r = {1'b0,     w[WIDTH-1:1]};
      OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
      default: r = {w[0],     w[WIDTH-1:1]};
    endcase
    return r;
  endfunction

`ifdef SEQ_SHIFT_NIBBLE_EN
  localparam logic [CNT_W-1:0] CNT_NIBBLE = CNT_W'(4);

  // Four-bit right step with the same fill rules as step1; equivalent to
  // four consecutive step1 applications.
  function automatic logic [WIDTH-1:0] step4(input logic [WIDTH-1:0] w,
                                             input logic [1:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SRL:  r = {4'b0000,          w[WIDTH-1:4]};
      OP_SRA:  r = {{4{w[WIDTH-1]}},  w[WIDTH-1:4]};
      default: r = {w[3:0],           w[WIDTH-1:4]};
    endcase
    return r;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [1:0]       op_q,    op_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= OP_ROR;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the accept.
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          rem_d   = bus.in_cnt;
          op_d    = bus.in_op;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A zero count still costs one BUSY cycle, giving the cnt+1 latency.
        if (rem_q == CNT_ZERO) begin
          state_d = ST_DONE;
        end else begin
`ifdef SEQ_SHIFT_NIBBLE_EN
          if (rem_q >= CNT_NIBBLE) begin
            work_d = step4(work_q, op_q);
            rem_d  = rem_q - CNT_NIBBLE;
          end else begin
            work_d = step1(work_q, op_q);
            rem_d  = rem_q - CNT_ONE;
          end
`else
          work_d = step1(work_q, op_q);
          rem_d  = rem_q - CNT_ONE;
`endif
        end
      end

      ST_DONE: begin
        // Result is held until taken; return to IDLE costs one bubble cycle
        // before the next operand can be accepted.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from the registered state. out_data is the work
  // register itself, so it is visible (and moving) during BUSY.
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
  assign bus.out_data  = work_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_right_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_right_shifter
// Description : Self-checking bench for seq_right_shifter. A table of
//               directed operations with hand-computed results, followed by
//               hand-written sequences for result back-pressure and reset
//               in the middle of an operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_right_shifter;

  localparam int WIDTH   = 16;
  localparam int CNT_W   = 4;
  localparam int MAX_LAT = 40;

  logic clk;
  logic rst;

  seq_right_shifter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_right_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] exp;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int c);
`ifdef SEQ_SHIFT_NIBBLE_EN
    return (c / 4) + (c % 4) + 1;
`else
    return c + 1;
`endif
  endfunction

  // Accept one operation, measure its latency, check the result and the
  // handshake back to IDLE. Called and returns at posedge+1.
  task automatic run_op(input int idx, input logic [1:0] op,
                        input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] cnt,
                        input logic [WIDTH-1:0] exp);
    int lat;
    check($sformatf("v%0d in_ready before", idx), 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_cnt   = cnt;
    bus.in_op    = op;
    @(posedge clk); #1;
    // Inputs are don't-care once accepted; scramble them.
    bus.in_valid = 1'b0;
    bus.in_data  = WIDTH'($urandom);
    bus.in_cnt   = CNT_W'($urandom);
    bus.in_op    = 2'($urandom);
    check($sformatf("v%0d busy after accept", idx), 32'(bus.busy), 32'd1);
    check($sformatf("v%0d in_ready after accept", idx), 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < MAX_LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_lat(int'(cnt))));
    check($sformatf("v%0d out_data", idx), 32'(bus.out_data), 32'(exp));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check($sformatf("v%0d out_valid after take", idx), 32'(bus.out_valid), 32'd0);
    check($sformatf("v%0d in_ready after take", idx), 32'(bus.in_ready), 32'd1);
    check($sformatf("v%0d busy after take", idx), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    total = 0;
    bad   = 0;

    //         op     data      cnt    expected
    vecs[0]  = '{2'b00, 16'h8001, 4'd1,  16'hC000};
    vecs[1]  = '{2'b01, 16'h8000, 4'd15, 16'h0001};
    vecs[2]  = '{2'b10, 16'h8000, 4'd4,  16'hF800};
    vecs[3]  = '{2'b10, 16'h7FF0, 4'd4,  16'h07FF};
    vecs[4]  = '{2'b11, 16'h1234, 4'd0,  16'h1234};
    vecs[5]  = '{2'b00, 16'h1234, 4'd8,  16'h3412};
    vecs[6]  = '{2'b10, 16'hF00F, 4'd15, 16'hFFFF};
    vecs[7]  = '{2'b01, 16'hFFFF, 4'd3,  16'h1FFF};
    vecs[8]  = '{2'b00, 16'h0001, 4'd15, 16'h0002};
    vecs[9]  = '{2'b10, 16'h8421, 4'd5,  16'hFC21};
    vecs[10] = '{2'b11, 16'hABCD, 4'd4,  16'hDABC};
    vecs[11] = '{2'b01, 16'h1234, 4'd0,  16'h1234};
    vecs[12] = '{2'b00, 16'h8001, 4'd7,  16'h0300};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cnt    = '0;
    bus.in_op     = 2'b00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_data",  32'(bus.out_data),  32'h0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy",      32'(bus.busy),      32'd0);
    check("reset in_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(i, vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].exp);
    end

    // Back-pressure: result held while out_ready is low, new requests ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hABCD;
    bus.in_cnt   = 4'd0;
    bus.in_op    = 2'b01;
    @(posedge clk); #1;
    bus.in_data  = 16'h5555;
    bus.in_cnt   = 4'd2;
    bus.in_op    = 2'b10;
    lat = 0;
    while (!bus.out_valid && lat < MAX_LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold reached DONE", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d out_data", k),  32'(bus.out_data),  32'hABCD);
      check($sformatf("hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d in_ready", k),  32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("hold take out_valid", 32'(bus.out_valid), 32'd0);
    check("hold take in_ready",  32'(bus.in_ready),  32'd1);
    check("hold take busy",      32'(bus.busy),      32'd0);

    // Reset three cycles into a cnt=10 operation.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    bus.in_cnt   = 4'd10;
    bus.in_op    = 2'b01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst out_data",  32'(bus.out_data),  32'h0);
    check("midrst in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst busy",      32'(bus.busy),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) lat++;
    end
    check("midrst no result", 32'(lat), 32'd0);
    run_op(100, 2'b00, 16'h0001, 4'd1, 16'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
